// File: rtl/led_pattern_sched.sv
// led_pattern_sched: shares LEDR between four pattern sources.
// Optional graceful drain on mode change: LED_SCHED_GRACEFUL_EN.
module led_pattern_sched #(
  parameter int TICK_DIV    = 131072,
  parameter int BLANK_TICKS = 2,
  parameter int DRAIN_TICKS = 32
) (
  input  logic        ADC_CLK_10,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  sel,
  input  logic [39:0] src_leds,
  input  logic [3:0]  src_done,
  output logic        tick,
  output logic [3:0]  src_start,
  output logic [3:0]  src_active,
  output logic [9:0]  LEDR,
  output logic [2:0]  state
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int TMAX = (BLANK_TICKS > DRAIN_TICKS) ?
                        BLANK_TICKS : DRAIN_TICKS;
  localparam int TW   = $clog2(TMAX + 1) + 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] B_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] D_LAST = TW'(DRAIN_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    BLANK = 3'd4
  } st_t;

  st_t             st;
  st_t             st_n;
  logic [1:0]      cur;
  logic [1:0]      cur_n;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic [9:0]      cur_leds;
  logic [9:0]      led_n;
  logic [3:0]      cur_hot;
  logic            owns;
  logic            done_cur;
  logic            blank_done;
  logic            drain_done;

  assign tick       = (pcnt == P_LAST);
  assign cur_hot    = 4'b0001 << cur;
  assign done_cur   = src_done[cur];
  assign blank_done = (BLANK_TICKS == 0) ||
                      (tick && (tcnt == B_LAST));
  assign drain_done = (DRAIN_TICKS == 0) ||
                      (tick && (tcnt == D_LAST));
  assign owns       = (st == START) || (st == RUN) ||
                      (st == DRAIN);

  assign src_start  = (st == START) ? cur_hot : 4'b0000;
  assign src_active = owns ? cur_hot : 4'b0000;
  assign state      = st;

  // Free-running prescaler producing the shared advance strobe
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset_n)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  // Select the pattern of the source currently owning LEDR
  always_comb begin
    cur_leds = src_leds[9:0];
    unique case (cur)
      2'd0: cur_leds = src_leds[9:0];
      2'd1: cur_leds = src_leds[19:10];
      2'd2: cur_leds = src_leds[29:20];
      2'd3: cur_leds = src_leds[39:30];
    endcase
  end

  // Mode sequencing: next state and next owner
  always_comb begin
    st_n  = st;
    cur_n = cur;
    unique case (st)
      IDLE: begin
        if (en) begin
          cur_n = sel;
          st_n  = START;
        end
      end
      START: st_n = RUN;
      RUN: begin
        if (sel != cur) begin
`ifdef LED_SCHED_GRACEFUL_EN
          st_n = done_cur ? BLANK : DRAIN;
`else
          st_n = BLANK;
`endif
        end
      end
      DRAIN: begin
        if (sel == cur)
          st_n = RUN;
        else if (done_cur || drain_done)
          st_n = BLANK;
      end
      BLANK: begin
        if (blank_done) begin
          cur_n = sel;
          st_n  = START;
        end
      end
      default: st_n = IDLE;
    endcase
    if (!en) begin
      st_n  = IDLE;
      cur_n = cur;
    end
  end

  // LEDR follows the owner only while it keeps ownership
  always_comb begin
    led_n = 10'd0;
    if ((st_n == RUN) || (st_n == DRAIN))
      led_n = cur_leds;
  end

  // State, owner and LED registers
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset_n) begin
      st   <= IDLE;
      cur  <= 2'd0;
      LEDR <= 10'd0;
    end else begin
      st   <= st_n;
      cur  <= cur_n;
      LEDR <= led_n;
    end
  end

  // Tick counter for drain/blank, cleared on every state change
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset_n)
      tcnt <= '0;
    else if (st_n != st)
      tcnt <= '0;
    else if (tick && ((st == DRAIN) || (st == BLANK)))
      tcnt <= tcnt + TW'(1);
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: directed checks of led_pattern_sched.
// TICK_DIV=4, BLANK_TICKS=2, DRAIN_TICKS=3.
module tb_led_pattern_sched;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [1:0]  sel;
  logic [39:0] src_leds;
  logic [3:0]  src_done;
  logic        tick;
  logic [3:0]  src_start;
  logic [3:0]  src_active;
  logic [9:0]  LEDR;
  logic [2:0]  state;

  int ntests = 0;
  int nfail  = 0;

`ifdef LED_SCHED_GRACEFUL_EN
  localparam logic [2:0] SW_ST = 3'd3;
`else
  localparam logic [2:0] SW_ST = 3'd4;
`endif

  led_pattern_sched #(
    .TICK_DIV(4),
    .BLANK_TICKS(2),
    .DRAIN_TICKS(3)
  ) dut (
    .ADC_CLK_10(clk),
    .reset_n(reset_n),
    .en(en),
    .sel(sel),
    .src_leds(src_leds),
    .src_done(src_done),
    .tick(tick),
    .src_start(src_start),
    .src_active(src_active),
    .LEDR(LEDR),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    sel      = 2'd0;
    src_done = 4'd0;
    src_leds = {10'h200, 10'h133, 10'h0A2, 10'h011};

    // reset then idle: tick period
    step(1);
    reset_n = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_leds", LEDR, 0);
    chk("rst_act", src_active, 0);
    chk("rst_start", src_start, 0);
    chk("rst_tick", tick, 0);
    for (int i = 1; i < 20; i++) begin
      step(1);
      chk($sformatf("tick_c%0d", i), tick, (i % 4) == 3);
    end
    chk("idle_state", state, 0);

    // startup on source 3
    reset_n = 1'b0;
    en = 1'b1;
    sel = 2'd3;
    step(1);
    reset_n = 1'b1;
    chk("su_idle", state, 0);
    step(1);
    chk("su_st_start", state, 1);
    chk("su_start", src_start, 4'b1000);
    chk("su_act1", src_active, 4'b1000);
    chk("su_led1", LEDR, 0);
    step(1);
    chk("su_st_run", state, 2);
    chk("su_start0", src_start, 0);
    chk("su_act2", src_active, 4'b1000);
    chk("su_led2", LEDR, 10'h200);

`ifndef LED_SCHED_GRACEFUL_EN
    // immediate switch 3 -> 1
    sel = 2'd1;
    step(1);
    chk("im_blank", state, 4);
    chk("im_led0", LEDR, 0);
    chk("im_act0", src_active, 0);
    step(4);
    chk("im_blank7", state, 4);
    chk("im_led7", LEDR, 0);
    step(1);
    chk("im_st_start", state, 1);
    chk("im_start", src_start, 4'b0010);
    chk("im_act", src_active, 4'b0010);
    step(1);
    chk("im_run", state, 2);
    chk("im_led", LEDR, 10'h0A2);
    src_leds[19:10] = 10'h155;
    step(1);
    chk("im_lat", LEDR, 10'h155);
    en = 1'b0;
    step(1);
    chk("im_dis_st", state, 0);
    chk("im_dis_led", LEDR, 0);
    chk("im_dis_act", src_active, 0);
    src_leds[19:10] = 10'h0A2;
`else
    // graceful switch 0 -> 2 ended by src_done
    reset_n = 1'b0;
    en = 1'b1;
    sel = 2'd0;
    step(1);
    reset_n = 1'b1;
    step(2);
    chk("g1_run", state, 2);
    chk("g1_led", LEDR, 10'h011);
    sel = 2'd2;
    step(1);
    chk("g1_drain", state, 3);
    chk("g1_dled", LEDR, 10'h011);
    chk("g1_dact", src_active, 4'b0001);
    src_leds[9:0] = 10'h0F0;
    step(1);
    chk("g1_track", LEDR, 10'h0F0);
    step(1);
    src_done = 4'b0100;
    step(1);
    src_done = 4'b0000;
    chk("g1_other", state, 3);
    step(1);
    chk("g1_c7", state, 3);
    src_done = 4'b0001;
    step(1);
    src_done = 4'b0000;
    chk("g1_blank", state, 4);
    chk("g1_bled", LEDR, 0);
    chk("g1_bact", src_active, 0);
    step(7);
    chk("g1_c15", state, 4);
    step(1);
    chk("g1_start", src_start, 4'b0100);
    step(1);
    chk("g1_run2", state, 2);
    chk("g1_led2", LEDR, 10'h133);

    // graceful switch 2 -> 0 by timeout
    sel = 2'd0;
    step(1);
    chk("g2_drain", state, 3);
    step(9);
    chk("g2_c27", state, 3);
    step(1);
    chk("g2_blank", state, 4);
    step(8);
    chk("g2_start", src_start, 4'b0001);
    step(1);
    chk("g2_led", LEDR, 10'h0F0);

    // revert during drain
    sel = 2'd2;
    step(1);
    chk("g3_drain", state, 3);
    chk("g3_dled", LEDR, 10'h0F0);
    sel = 2'd0;
    step(1);
    chk("g3_run", state, 2);
    chk("g3_nostart", src_start, 0);
    chk("g3_led", LEDR, 10'h0F0);
    step(1);
    chk("g3_run2", state, 2);
    chk("g3_nostart2", src_start, 0);

    // done coincident with sel change
    sel = 2'd1;
    src_done = 4'b0001;
    step(1);
    src_done = 4'b0000;
    chk("g4_blank", state, 4);
    src_leds[9:0] = 10'h011;
`endif

    // disable mid-switch, then reset in BLANK
    reset_n = 1'b0;
    en = 1'b1;
    sel = 2'd0;
    step(1);
    reset_n = 1'b1;
    step(2);
    sel = 2'd2;
    step(1);
    chk("d_switch", state, SW_ST);
    en = 1'b0;
    step(1);
    chk("d_idle", state, 0);
    chk("d_led", LEDR, 0);
    chk("d_act", src_active, 0);
    en = 1'b1;
    step(1);
    chk("d_start", src_start, 4'b0100);
    step(1);
    chk("d_led2", LEDR, 10'h133);
    sel = 2'd1;
    step(1);
    src_done = 4'b0100;
    step(1);
    src_done = 4'b0000;
    chk("r_blank", state, 4);
    reset_n = 1'b0;
    step(1);
    chk("r_state", state, 0);
    chk("r_led", LEDR, 0);
    chk("r_act", src_active, 0);
    chk("r_start", src_start, 0);
    chk("r_tick", tick, 0);
    reset_n = 1'b1;
    step(1);
    chk("r_restart", src_start, 4'b0010);
    step(1);
    chk("r_led2", LEDR, 10'h0A2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
